branch_metric: RTL
==================

Name: branch_metric

Overview:
- Upstream feeder of the forward (alpha) recursion in the 8-state max-log-MAP SISO decoder.
- Accepts one systematic/parity/a-priori LLR triple per trellis step over a valid/ready handshake.
- Computes the two distinct branch metrics of the RSC trellis.
- Presents them as init_branch1/init_branch2 with a single-cycle valid_branch pulse, always followed by at least one idle cycle. The alpha stage uses the idle cycle to commit its state registers.

Parameters:
- IN_W, 8: width of signed channel LLRs (systematic, parity).
- APR_W, 16: width of signed a-priori LLR.
- OUT_W, 16: width of signed branch metric outputs.
- K_W, 13: block-length counter width (max block 6144).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a block, latches blk_len
- blk_len  in  K_W  number of trellis steps in block, 1..6144
- s_valid  in  1  input triple valid
- s_ready  out  1  block accepts triple this cycle
- sys_llr  in  IN_W  signed systematic LLR
- par_llr  in  IN_W  signed parity LLR
- apr_llr  in  APR_W  signed a-priori LLR
- init_branch1  out  OUT_W  metric b1 = (sys+apr+par)>>>1
- init_branch2  out  OUT_W  metric b2 = (sys+apr-par)>>>1
- valid_branch  out  1  one-cycle pulse, metrics valid
- branch_last  out  1  high with valid_branch on the final step of the block
- busy  out  1  block in progress
- err_len  out  1  one-cycle pulse when start is given with blk_len==0

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counter=0, init_branch1/2=0, valid_branch=0, branch_last=0, busy=0, err_len=0. s_ready=0 while in IDLE.
- FSM states: IDLE, ACCEPT, GAP.
- IDLE, start=1, blk_len!=0: latch blk_len, clear counter, go to ACCEPT, busy=1 from the next cycle.
- IDLE, start=1, blk_len==0: err_len=1 for the next cycle only. Stay in IDLE.
- ACCEPT: s_ready=1 (combinational from state).
  - On fire (s_valid&&s_ready): register b1/b2, valid_branch=1 next cycle, increment counter, go to GAP.
  - If the counter reaches blk_len on this fire, branch_last=1 together with that valid_branch.
  - With no fire: stay in ACCEPT; metrics hold; valid_branch=0.
- GAP: s_ready=0; valid_branch returns to 0.
  - After exactly 1 cycle, return to ACCEPT if steps remain, else go to IDLE (busy=0 on the same edge).
- Latency: fire at cycle t gives valid_branch and metrics at cycle t+1.
- Peak throughput: one step per 2 cycles. valid_branch is never high on two consecutive cycles.
- init_branch1/2 hold their last value between pulses and across the block end. They clear only on reset.
- Arithmetic:
  - Sign-extend all inputs to APR_W+2 bits.
  - s1=sys+apr+par and s2=sys+apr-par, exact.
  - Arithmetic shift right by 1 (floor rounding).
  - The result fits in OUT_W for default widths (max |value| 16512), so no saturation logic is used. Truncation to OUT_W is lossless.
- start while busy is ignored; the block is neither restarted nor extended, and err_len stays 0.
- s_valid while not in ACCEPT is ignored (no fire).
- rst low mid-block aborts immediately. Partial-block state is discarded and the next start begins from step 0.

Decomposition:
- Shared package siso_pkg holds:
  - width constants: IN_W, APR_W, OUT_W, K_W, MAX_K=6144
  - FSM state enum bm_state_t {IDLE, ACCEPT, GAP}
  - typedef metric_t (logic signed [OUT_W-1:0]), shared with the alpha and beta stages
- No sub-module is needed. The metric datapath is two adders plus a shift, kept inline.

Test Plan:
1. start, blk_len=1; sys=10, par=4, apr=0 -> one cycle after fire: init_branch1=7, init_branch2=3, valid_branch=1, branch_last=1. Next cycle valid_branch=0; IDLE, busy=0.
2. sys=127, par=-128, apr=32767 -> b1=16383, b2=16511. sys=-128, par=127, apr=-32768 -> b1=-16385, b2=-16512 (floor rounding checked).
3. blk_len=3, s_valid held high -> s_ready pattern 1,0,1,0,1,0 then 0. valid_branch pulses exactly 3 times, two cycles apart. branch_last only on the third pulse.
4. blk_len=4, s_valid deasserted 5 cycles after step 2 -> s_ready stays 1 in ACCEPT, no valid_branch, metrics hold step-2 values. The block resumes and completes with 4 pulses total.
5. rst pulsed low mid-cycle after 2 of 5 steps -> all outputs 0 asynchronously. A new start with blk_len=2 yields exactly 2 pulses, last on the 2nd.
6. start with blk_len=0 -> err_len=1 for one cycle, s_ready stays 0. A second start issued while busy with blk_len=3 -> ignored; the original block completes unchanged.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared widths and types for the max-log-MAP SISO decoder stages.
// The alpha and beta stages also use metric_t from here.
package siso_pkg;
  localparam int IN_W  = 8;
  localparam int APR_W = 16;
  localparam int OUT_W = 16;
  localparam int K_W   = 13;
  localparam int MAX_K = 6144;

  typedef enum logic [1:0] {IDLE, ACCEPT, GAP} bm_state_t;

  typedef logic signed [OUT_W-1:0] metric_t;
  typedef logic signed [IN_W-1:0]  llr_t;
  typedef logic signed [APR_W-1:0] apr_t;
endpackage

// File: rtl/branch_metric_if.sv
// LLR input handshake and branch-metric output bundle between the feeder and the alpha stage.
interface branch_metric_if;
  import siso_pkg::*;

  logic    s_valid;
  logic    s_ready;
  llr_t    sys_llr;
  llr_t    par_llr;
  apr_t    apr_llr;
  metric_t init_branch1;
  metric_t init_branch2;
  logic    valid_branch;
  logic    branch_last;

  modport slave (
    input  s_valid, sys_llr, par_llr, apr_llr,
    output s_ready, init_branch1, init_branch2, valid_branch, branch_last
  );

  modport master (
    output s_valid, sys_llr, par_llr, apr_llr,
    input  s_ready, init_branch1, init_branch2, valid_branch, branch_last
  );
endinterface

// File: rtl/branch_metric.sv
// Branch metric feeder: one LLR triple per step in, two RSC branch metrics out,
// each valid pulse followed by an idle cycle so the alpha stage can commit.
module branch_metric
  import siso_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [K_W-1:0]  blk_len,
  branch_metric_if.slave  bm,
  output logic            busy,
  output logic            err_len
);

  localparam int SW = APR_W + 2;

  bm_state_t        r_state;
  logic [K_W-1:0]   r_cnt;
  logic [K_W-1:0]   r_len;
  metric_t          r_b1;
  metric_t          r_b2;
  logic             r_vld;
  logic             r_last;
  logic             r_busy;
  logic             r_err;

  logic             w_ready;
  logic             w_fire;
  logic [K_W-1:0]   w_cnt_nxt;
  logic signed [SW-1:0] w_sys, w_par, w_apr, w_s1, w_s2;
  metric_t          w_b1;
  metric_t          w_b2;

  assign w_ready   = (r_state == ACCEPT);
  assign w_fire    = bm.s_valid && w_ready;
  assign w_cnt_nxt = r_cnt + K_W'(1);

  // Exact sums at APR_W+2 bits; the >>> on a signed operand floors toward -inf.
  assign w_sys = SW'(bm.sys_llr);
  assign w_par = SW'(bm.par_llr);
  assign w_apr = SW'(bm.apr_llr);
  assign w_s1  = w_sys + w_apr + w_par;
  assign w_s2  = w_sys + w_apr - w_par;
  assign w_b1  = metric_t'(w_s1 >>> 1);
  assign w_b2  = metric_t'(w_s2 >>> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_b1    <= '0;
      r_b2    <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (blk_len != '0) begin
              r_len   <= blk_len;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= ACCEPT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (w_fire) begin
            r_b1    <= w_b1;
            r_b2    <= w_b2;
            r_vld   <= 1'b1;
            r_last  <= (w_cnt_nxt == r_len);
            r_cnt   <= w_cnt_nxt;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_cnt == r_len) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ACCEPT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bm.s_ready      = w_ready;
  assign bm.init_branch1 = r_b1;
  assign bm.init_branch2 = r_b2;
  assign bm.valid_branch = r_vld;
  assign bm.branch_last  = r_last;
  assign busy            = r_busy;
  assign err_len         = r_err;

endmodule
